// File: rtl/conv_col_sequencer.sv
// Frame-level column sequencer for the row-parallel convolution array.
// Loads K kernel columns, then streams PN zero-padded image columns per
// input channel, tagging each issued column with window-completion and
// channel flags for the engine bank.
`timescale 1ns/1ps

module conv_col_sequencer #(
    parameter int DATA_WIDTH  = 16,
    parameter int KERNEL_SIZE = 3,
    parameter int IMAGE_SIZE  = 12,
    parameter int STRIDE      = 1,
    parameter int PADDING     = 1,
    parameter int CHANNELS    = 1
) (
    input  logic                                                   clk,
    input  logic                                                   rst,
    input  logic                                                   start,
    input  logic [DATA_WIDTH*KERNEL_SIZE-1:0]                      k_data,
    input  logic                                                   k_valid,
    output logic                                                   k_ready,
    input  logic [DATA_WIDTH*IMAGE_SIZE-1:0]                       px_data,
    input  logic                                                   px_valid,
    output logic                                                   px_ready,
    output logic [DATA_WIDTH*(IMAGE_SIZE+2*PADDING)-1:0]           eng_col,
    output logic                                                   eng_kernel_load,
    output logic [$clog2(KERNEL_SIZE)-1:0]                         eng_kcol,
    output logic                                                   eng_valid,
    output logic [$clog2(IMAGE_SIZE+2*PADDING)-1:0]                eng_pcol,
    output logic                                                   eng_win_done,
    output logic [$clog2((IMAGE_SIZE+2*PADDING-KERNEL_SIZE)/STRIDE+1):0] eng_ocol,
    output logic                                                   eng_first_ch,
    output logic                                                   eng_last_ch,
    output logic                                                   busy,
    output logic                                                   done
);

    localparam int PN       = IMAGE_SIZE + 2*PADDING;
    localparam int OUT_SIZE = (PN - KERNEL_SIZE)/STRIDE + 1;
    localparam int KC_W     = $clog2(KERNEL_SIZE);
    localparam int PC_W     = $clog2(PN);
    localparam int OC_W     = $clog2(OUT_SIZE) + 1;
    localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int SP_W     = (STRIDE > 1) ? $clog2(STRIDE) : 1;
    localparam int COL_W    = DATA_WIDTH*PN;

    localparam logic [KC_W-1:0] K_LAST   = KC_W'(KERNEL_SIZE-1);
    localparam logic [PC_W-1:0] COL_LAST = PC_W'(PN-1);
    localparam logic [PC_W-1:0] COL_KM1  = PC_W'(KERNEL_SIZE-1);
    localparam logic [PC_W:0]   REAL_LO  = (PC_W+1)'(PADDING);
    localparam logic [PC_W:0]   REAL_CNT = (PC_W+1)'(IMAGE_SIZE);
    localparam logic [CH_W-1:0] CH_LAST  = CH_W'(CHANNELS-1);
    localparam logic [SP_W-1:0] SP_LAST  = SP_W'(STRIDE-1);
    localparam logic [OC_W-1:0] OUT_C    = OC_W'(OUT_SIZE);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD_K,
        S_STREAM,
        S_DONE
    } state_t;

    state_t            state, state_n;
    logic [CH_W-1:0]   ch, ch_n;
    logic [KC_W-1:0]   kcnt, kcnt_n;
    logic [PC_W-1:0]   col, col_n;
    logic [SP_W-1:0]   sp, sp_n;
    logic [OC_W-1:0]   oc, oc_n;

    logic [COL_W-1:0]  eng_col_n;
    logic              kl_n, valid_n, win_n, first_n, last_n, done_n;
    logic [KC_W-1:0]   kcol_n;
    logic [PC_W-1:0]   pcol_n;
    logic [OC_W-1:0]   ocol_n;

    // Offset from the first real column; columns left of the image wrap
    // to a large value, so a single compare selects the image region.
    logic [PC_W:0]     rel_col;
    logic              is_real;

    assign rel_col = {1'b0, col} - REAL_LO;
    assign is_real = (rel_col < REAL_CNT);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state, handshake and engine-output computation
    always_comb begin
        state_n   = state;
        ch_n      = ch;
        kcnt_n    = kcnt;
        col_n     = col;
        sp_n      = sp;
        oc_n      = oc;
        eng_col_n = eng_col;
        kl_n      = 1'b0;
        kcol_n    = eng_kcol;
        valid_n   = 1'b0;
        pcol_n    = eng_pcol;
        win_n     = 1'b0;
        ocol_n    = '0;
        first_n   = eng_first_ch;
        last_n    = eng_last_ch;
        done_n    = 1'b0;
        k_ready   = 1'b0;
        px_ready  = 1'b0;
        busy      = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n = S_LOAD_K;
                    ch_n    = '0;
                    kcnt_n  = '0;
                    col_n   = '0;
                    sp_n    = '0;
                    oc_n    = '0;
                end
            end

            S_LOAD_K: begin
                busy    = 1'b1;
                k_ready = 1'b1;
                if (k_valid) begin
                    kl_n      = 1'b1;
                    kcol_n    = kcnt;
                    eng_col_n = '0;
                    eng_col_n[DATA_WIDTH*KERNEL_SIZE-1:0] = k_data;
                    first_n   = (ch == '0);
                    last_n    = (ch == CH_LAST);
                    if (kcnt == K_LAST) begin
                        kcnt_n  = '0;
                        col_n   = '0;
                        sp_n    = '0;
                        oc_n    = '0;
                        state_n = S_STREAM;
                    end else begin
                        kcnt_n = kcnt + KC_W'(1);
                    end
                end
            end

            S_STREAM: begin
                busy     = 1'b1;
                px_ready = is_real;
                if (!is_real || px_valid) begin
                    valid_n   = 1'b1;
                    pcol_n    = col;
                    eng_col_n = '0;
                    if (is_real) begin
                        eng_col_n[PADDING*DATA_WIDTH +: IMAGE_SIZE*DATA_WIDTH] = px_data;
                    end
                    first_n = (ch == '0);
                    last_n  = (ch == CH_LAST);
                    // Stride phase restarts at column K-1 each channel, so
                    // phase zero marks every STRIDE-th window end without a divider.
                    if (col >= COL_KM1) begin
                        if ((sp == '0) && (oc < OUT_C)) begin
                            win_n  = 1'b1;
                            ocol_n = oc;
                            oc_n   = oc + OC_W'(1);
                        end
                        sp_n = (sp == SP_LAST) ? '0 : sp + SP_W'(1);
                    end
                    if (col == COL_LAST) begin
                        col_n = '0;
                        if (ch == CH_LAST) begin
                            state_n = S_DONE;
                        end else begin
                            ch_n    = ch + CH_W'(1);
                            kcnt_n  = '0;
                            state_n = S_LOAD_K;
                        end
                    end else begin
                        col_n = col + PC_W'(1);
                    end
                end
            end

            S_DONE: begin
                done_n  = 1'b1;
                state_n = S_IDLE;
            end

            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // Counters and registered engine outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ch              <= '0;
            kcnt            <= '0;
            col             <= '0;
            sp              <= '0;
            oc              <= '0;
            eng_col         <= '0;
            eng_kernel_load <= 1'b0;
            eng_kcol        <= '0;
            eng_valid       <= 1'b0;
            eng_pcol        <= '0;
            eng_win_done    <= 1'b0;
            eng_ocol        <= '0;
            eng_first_ch    <= 1'b0;
            eng_last_ch     <= 1'b0;
            done            <= 1'b0;
        end else begin
            ch              <= ch_n;
            kcnt            <= kcnt_n;
            col             <= col_n;
            sp              <= sp_n;
            oc              <= oc_n;
            eng_col         <= eng_col_n;
            eng_kernel_load <= kl_n;
            eng_kcol        <= kcol_n;
            eng_valid       <= valid_n;
            eng_pcol        <= pcol_n;
            eng_win_done    <= win_n;
            eng_ocol        <= ocol_n;
            eng_first_ch    <= first_n;
            eng_last_ch     <= last_n;
            done            <= done_n;
        end
    end

endmodule
